// File: rtl/fib_sequence_counter_pkg.sv
// rtl/fib_sequence_counter_pkg.sv - shared types and constants for the Fibonacci sequence counter
//
// Purpose: FSM state type and MODE encodings used by the counter, its
// interface users and the step helper.
package fib_sequence_counter_pkg;

    // RUN advances on EN; HALT is the one-shot parking state left only by CLR/reset.
    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } fsm_state_t;

    localparam logic MODE_LOOP    = 1'b0;
    localparam logic MODE_ONESHOT = 1'b1;

endpackage

// File: rtl/fib_sequence_counter_if.sv
// rtl/fib_sequence_counter_if.sv - control/status bundle of the Fibonacci sequence counter
//
// Purpose: groups the step controls and sequence outputs.
// Signals:
//   EN    advance one step per cycle while high
//   CLR   synchronous restart to seed, priority over EN
//   MODE  0 = loop, 1 = one-shot
//   O     current sequence value
//   IDX   steps since last seed load, saturating
//   WRAP  one-cycle pulse when a loop-mode wrap returns O to seed
//   DONE  high while halted in one-shot mode
interface fib_sequence_counter_if #(
    parameter int WIDTH = 4,
    parameter int IDX_W = 4
);
    logic             EN;
    logic             CLR;
    logic             MODE;
    logic [WIDTH-1:0] O;
    logic [IDX_W-1:0] IDX;
    logic             WRAP;
    logic             DONE;

    modport master (
        output EN, CLR, MODE,
        input  O, IDX, WRAP, DONE
    );

    modport slave (
        input  EN, CLR, MODE,
        output O, IDX, WRAP, DONE
    );
endinterface

// File: rtl/fib_sequence_counter_step.sv
// rtl/fib_sequence_counter_step.sv - combinational next-value and terminal detection
//
// Purpose: computes prev+cur one bit wider than the state so an overflowing
// sum is still seen as exceeding LIMIT.
// Ports:
//   prev_i, cur_i  current pair of sequence values
//   next_o         low WIDTH bits of the sum
//   terminal_o     sum exceeds LIMIT
module fib_step #(
    parameter int          WIDTH = 4,
    parameter int unsigned LIMIT = (2**WIDTH) - 1
) (
    input  logic [WIDTH-1:0] prev_i,
    input  logic [WIDTH-1:0] cur_i,
    output logic [WIDTH-1:0] next_o,
    output logic             terminal_o
);
    localparam logic [WIDTH:0] LIMIT_W = (WIDTH+1)'(LIMIT);

    logic [WIDTH:0] sum;

    assign sum        = {1'b0, prev_i} + {1'b0, cur_i};
    assign next_o     = sum[WIDTH-1:0];
    assign terminal_o = (sum > LIMIT_W);
endmodule

// File: rtl/fib_sequence_counter.sv
// rtl/fib_sequence_counter.sv - parametrised Fibonacci-style sequence counter
//
// Purpose: each enabled step outputs prev+cur; a step whose sum exceeds
// LIMIT either wraps to SEED (loop mode) or halts (one-shot mode).
// Ports:
//   CLK    rising-edge clock
//   RST_N  asynchronous active-low reset
//   bus    slave side of fib_sequence_counter_if (EN/CLR/MODE in, O/IDX/WRAP/DONE out)
module fib_sequence_counter
    import fib_sequence_counter_pkg::*;
#(
    parameter int          WIDTH = 4,
    parameter int unsigned LIMIT = (2**WIDTH) - 1,
    parameter int unsigned SEED  = 1,
    parameter int          IDX_W = 4
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    fib_sequence_counter_if.slave bus
);
    // A zero seed would stick at zero forever; a seed above LIMIT never yields a legal value.
    if (WIDTH < 2 || SEED < 1 || SEED > LIMIT || LIMIT > (2**WIDTH) - 1) begin : g_param_check
        $error("fib_sequence_counter: illegal WIDTH/LIMIT/SEED combination");
    end

    localparam logic [WIDTH-1:0] SEED_W = WIDTH'(SEED);

    fsm_state_t       state_q, state_d;
    logic [WIDTH-1:0] prev_q, prev_d;
    logic [WIDTH-1:0] cur_q, cur_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             wrap_q, wrap_d;

    logic [WIDTH-1:0] next_val;
    logic             terminal;

    fib_step #(
        .WIDTH (WIDTH),
        .LIMIT (LIMIT)
    ) u_step (
        .prev_i     (prev_q),
        .cur_i      (cur_q),
        .next_o     (next_val),
        .terminal_o (terminal)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= RUN;
            prev_q  <= SEED_W;
            cur_q   <= SEED_W;
            idx_q   <= '0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            prev_q  <= prev_d;
            cur_q   <= cur_d;
            idx_q   <= idx_d;
            wrap_q  <= wrap_d;
        end
    end

    // CLR beats everything; HALT and idle RUN fall through to the hold defaults.
    always_comb begin
        state_d = state_q;
        prev_d  = prev_q;
        cur_d   = cur_q;
        idx_d   = idx_q;
        wrap_d  = 1'b0;

        if (bus.CLR) begin
            state_d = RUN;
            prev_d  = SEED_W;
            cur_d   = SEED_W;
            idx_d   = '0;
        end else if (state_q == RUN && bus.EN) begin
            if (!terminal) begin
                prev_d = cur_q;
                cur_d  = next_val;
                if (idx_q != '1) begin
                    idx_d = idx_q + 1'b1;
                end
            end else if (bus.MODE == MODE_LOOP) begin
                prev_d = SEED_W;
                cur_d  = SEED_W;
                idx_d  = '0;
                wrap_d = 1'b1;
            end else begin
                // One-shot: O keeps the last legal value.
                state_d = HALT;
            end
        end
    end

    assign bus.O    = cur_q;
    assign bus.IDX  = idx_q;
    assign bus.WRAP = wrap_q;
    assign bus.DONE = (state_q == HALT);
endmodule

// File: tb/tb_fib_sequence_counter.sv
// tb/tb_fib_sequence_counter.sv - testbench for fib_sequence_counter
module tb_fib_sequence_counter;
    logic CLK = 1'b0;
    logic RST_N;

    always #5 CLK = ~CLK;

    fib_sequence_counter_if #(.WIDTH(4), .IDX_W(4)) if0 ();
    fib_sequence_counter_if #(.WIDTH(8), .IDX_W(4)) if1 ();
    fib_sequence_counter_if #(.WIDTH(8), .IDX_W(4)) if2 ();

    fib_sequence_counter #(.WIDTH(4)) u_def (
        .CLK (CLK), .RST_N (RST_N), .bus (if0)
    );
    fib_sequence_counter #(.WIDTH(8), .LIMIT(100)) u_w8 (
        .CLK (CLK), .RST_N (RST_N), .bus (if1)
    );
    fib_sequence_counter #(.WIDTH(8), .LIMIT(255)) u_w8f (
        .CLK (CLK), .RST_N (RST_N), .bus (if2)
    );

    int errors = 0;
    int checks = 0;

    // Reference: each instance's legal value list from seed, and a position in it.
    int lim [3] = '{15, 100, 255};
    int seq [3][$];
    int pos [3];
    bit hlt [3];
    bit wrp [3];

    task automatic chk(string tag, logic [31:0] obs, int exp);
        checks++;
        assert (obs === 32'(exp)) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic build_model();
        for (int k = 0; k < 3; k++) begin
            int p, c, s;
            seq[k].delete();
            p = 1;
            c = 1;
            seq[k].push_back(1);
            forever begin
                s = p + c;
                if (s > lim[k]) break;
                seq[k].push_back(s);
                p = c;
                c = s;
            end
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            pos[k] = 0;
            hlt[k] = 1'b0;
            wrp[k] = 1'b0;
        end
    endtask

    task automatic model_step(bit en, bit clr, bit mode);
        for (int k = 0; k < 3; k++) begin
            wrp[k] = 1'b0;
            if (clr) begin
                pos[k] = 0;
                hlt[k] = 1'b0;
            end else if (!hlt[k] && en) begin
                if (pos[k] + 1 < seq[k].size()) pos[k]++;
                else if (!mode) begin
                    pos[k] = 0;
                    wrp[k] = 1'b1;
                end else hlt[k] = 1'b1;
            end
        end
    endtask

    task automatic get_obs(int k, output logic [31:0] o, output logic [31:0] ix,
                           output logic w, output logic d);
        case (k)
            0: begin o = 32'(if0.O); ix = 32'(if0.IDX); w = if0.WRAP; d = if0.DONE; end
            1: begin o = 32'(if1.O); ix = 32'(if1.IDX); w = if1.WRAP; d = if1.DONE; end
            default: begin o = 32'(if2.O); ix = 32'(if2.IDX); w = if2.WRAP; d = if2.DONE; end
        endcase
    endtask

    task automatic check_all(string tag);
        for (int k = 0; k < 3; k++) begin
            logic [31:0] o, ix;
            logic w, d;
            get_obs(k, o, ix, w, d);
            chk($sformatf("%s[%0d].O", tag, k), o, seq[k][pos[k]]);
            chk($sformatf("%s[%0d].IDX", tag, k), ix, (pos[k] > 15) ? 15 : pos[k]);
            chk($sformatf("%s[%0d].WRAP", tag, k), {31'b0, w}, int'(wrp[k]));
            chk($sformatf("%s[%0d].DONE", tag, k), {31'b0, d}, int'(hlt[k]));
        end
    endtask

    task automatic drive(bit en, bit clr, bit mode);
        if0.EN = en; if0.CLR = clr; if0.MODE = mode;
        if1.EN = en; if1.CLR = clr; if1.MODE = mode;
        if2.EN = en; if2.CLR = clr; if2.MODE = mode;
    endtask

    task automatic cycle(bit en, bit clr, bit mode, string tag);
        drive(en, clr, mode);
        @(posedge CLK);
        #1;
        model_step(en, clr, mode);
        check_all(tag);
    endtask

    initial begin
        build_model();
        RST_N = 1'b0;
        drive(1'b0, 1'b0, 1'b0);
        repeat (2) @(posedge CLK);
        #1;
        model_reset();
        check_all("reset");
        chk("reset_O_const", 32'(if0.O), 1);
        @(negedge CLK);
        RST_N = 1'b1;

        // Loop mode: default wraps after 13, LIMIT=100 after 89, LIMIT=255 after 233.
        for (int i = 1; i <= 12; i++) begin
            cycle(1'b1, 1'b0, 1'b0, "loop");
            if (i == 5) chk("def_13", 32'(if0.O), 13);
            if (i == 6) chk("def_wrap", {31'b0, if0.WRAP}, 1);
            if (i == 9) chk("w8_89", 32'(if1.O), 89);
            if (i == 10) chk("w8_wrap", {31'b0, if1.WRAP}, 1);
            if (i == 11) chk("w8f_233", 32'(if2.O), 233);
            if (i == 12) chk("w8f_wrap", {31'b0, if2.WRAP}, 1);
        end

        // One-shot: default halts on 13.
        cycle(1'b0, 1'b1, 1'b0, "clr0");
        for (int i = 1; i <= 8; i++) cycle(1'b1, 1'b0, 1'b1, "oneshot");
        chk("oneshot_O", 32'(if0.O), 13);
        chk("oneshot_DONE", {31'b0, if0.DONE}, 1);
        cycle(1'b1, 1'b0, 1'b0, "halt_ignores_mode");
        cycle(1'b0, 1'b1, 1'b1, "clr_halt");
        chk("clr_halt_DONE", {31'b0, if0.DONE}, 0);

        // EN toggling from 3, then CLR with EN at 8.
        cycle(1'b1, 1'b0, 1'b0, "to2");
        cycle(1'b1, 1'b0, 1'b0, "to3");
        cycle(1'b1, 1'b0, 1'b0, "en1");
        cycle(1'b0, 1'b0, 1'b0, "en0a");
        cycle(1'b0, 1'b0, 1'b0, "en0b");
        cycle(1'b1, 1'b0, 1'b0, "en1b");
        chk("toggle_8", 32'(if0.O), 8);
        cycle(1'b1, 1'b1, 1'b0, "clr_en");

        // Asynchronous reset mid-sequence at 13.
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 1'b0, "to13");
        drive(1'b0, 1'b0, 1'b0);
        #2 RST_N = 1'b0;
        #1;
        model_reset();
        check_all("areset");
        @(negedge CLK);
        RST_N = 1'b1;
        cycle(1'b1, 1'b0, 1'b0, "resume2");
        cycle(1'b1, 1'b0, 1'b0, "resume3");

        // CLR on the terminal edge in one-shot mode.
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b1, "to13b");
        chk("pre_term_13", 32'(if0.O), 13);
        cycle(1'b1, 1'b1, 1'b1, "clr_term");
        chk("clr_term_DONE", {31'b0, if0.DONE}, 0);

        // Randomised controls.
        for (int i = 0; i < 400; i++) begin
            cycle($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0,
                  1'($urandom_range(0, 1)), "rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/fib_sequence_counter.md
Name: fib_sequence_counter

Overview:
Parametrised Fibonacci-style sequence counter: each enabled step outputs prev+cur. With default parameters it produces 1,2,3,5,8,13 and then wraps back to 1. Unlike the earlier fixed 4-bit hard-wired sequence counter, it adds reset, enable, synchronous clear, a configurable width, limit and seed, and a loop or one-shot mode with status outputs. Sits as a free-running pattern or step source in lab/top-level designs.

Parameters:
WIDTH, 4, output/state width in bits (>=2)
LIMIT, 2**WIDTH-1, largest value allowed on O; a step whose sum exceeds it is a terminal step (SEED <= LIMIT <= 2**WIDTH-1)
SEED, 1, restart value loaded into both prev and cur (1 <= SEED <= LIMIT; 0 is illegal because the sequence would stick)
IDX_W, 4, width of the step-index output

Ports:
CLK  in  1  rising-edge clock
RST_N  in  1  asynchronous active-low reset
EN  in  1  advance one step per cycle while high
CLR  in  1  synchronous restart to seed; priority over EN
MODE  in  1  0 = loop (wrap to seed), 1 = one-shot (halt at last legal value)
O  out  WIDTH  current sequence value (registered)
IDX  out  IDX_W  steps taken since the last seed load; saturates at all-ones
WRAP  out  1  one-cycle pulse on the cycle O returns to SEED through a loop-mode wrap
DONE  out  1  level, high while halted in one-shot mode

Behaviour:
- One clock (CLK) and one asynchronous, active-low reset (RST_N).
- State: prev[WIDTH-1:0], cur[WIDTH-1:0], idx, and a 2-state FSM {RUN, HALT}. O = cur.
- Reset (RST_N low, asynchronous): prev=SEED, cur=SEED, idx=0, FSM=RUN, WRAP=0, DONE=0. Outputs are valid immediately after reset.
- sum = prev + cur, computed at WIDTH+1 bits so overflow is never lost. terminal = (sum > LIMIT), compared at WIDTH+1 bits.
- Priority each rising edge: CLR > HALT hold > EN step > idle hold.
- CLR=1 in any state: prev=cur=SEED, idx=0, FSM=RUN, WRAP=0, DONE=0.
- RUN, EN=1, !terminal: prev<=cur, cur<=sum[WIDTH-1:0], idx<=idx+1 (saturating). Latency: a new value appears on O in the cycle after the EN edge.
- RUN, EN=1, terminal, MODE=0: prev=cur=SEED, idx=0, WRAP=1 for exactly that cycle.
- RUN, EN=1, terminal, MODE=1: O holds, FSM->HALT, DONE=1, no WRAP.
- HALT: all state holds, and EN and MODE are ignored. Only CLR or reset leave HALT.
- EN=0 in RUN: everything holds. WRAP is 0 on every cycle except the wrap cycle.
- MODE is sampled only at the terminal step. Changing MODE mid-sequence has no other effect.
- CLR and a terminal step in the same cycle: CLR wins, so no WRAP and no DONE.
- Reset asserted mid-sequence or in HALT: immediate return to reset values, with no glitch pulse on WRAP.
- With defaults the cycle length is 6 values (1,2,3,5,8,13). After 13 the sum is 21 > 15, so the counter wraps.

Decomposition:
- Shared package: FSM state typedef {RUN, HALT} and mode constants MODE_LOOP=0, MODE_ONESHOT=1.
- Parameter legality checks (SEED>=1, SEED<=LIMIT, LIMIT<2**WIDTH) go in an elaboration-time assertion in the module.
- One natural sub-module, fib_step: combinational sum/terminal computation (inputs prev, cur; outputs next, terminal). Registers and FSM stay in the top module.

Test Plan:
- Reset then EN=1 for 7 cycles, defaults, MODE=0 -> O = 1,2,3,5,8,13,1. WRAP high only on the cycle O=1 reappears. IDX = 0,1,2,3,4,5,0.
- MODE=1, EN=1 for 8 cycles -> O = 1,2,3,5,8,13,13,13. DONE rises with the first held 13 and stays high. WRAP never asserts. CLR then returns O=1, DONE=0.
- Toggle EN (1,0,0,1) from O=3 -> O = 5,5,5,8. CLR asserted together with EN at O=8 -> O=1, IDX=0.
- Drop RST_N asynchronously between clock edges at O=13 -> O=1 before the next edge. Releasing reset then EN resumes 2,3,...
- WIDTH=8, LIMIT=100, MODE=0 -> O = 1,2,3,5,8,13,21,34,55,89,1, with WRAP on the final 1. WIDTH=8, LIMIT=255 -> ...,144,233,1, because the overflowed sum 377 is detected.
- CLR on the same edge as the terminal step (O=13, EN=1, MODE=1) -> O=1, DONE=0, WRAP=0.
